// File: rtl/text_memory_loader_pkg.sv
// Shared definitions for the text memory loader: FSM encoding and word/byte geometry.
package text_memory_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_WIDTH     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage : text_memory_loader_pkg

// File: rtl/text_memory_loader.sv
// Assembles a byte stream into little-endian 32-bit words and writes them to the text
// memory at word-aligned addresses from 0, holding the core off while a load is running.
module text_memory_loader
  import text_memory_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] word_count,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW        = ADDR_WIDTH - 1;
  localparam int unsigned MAX_WORDS = 1 << (ADDR_WIDTH - 2);
  localparam int unsigned IW        = $clog2(BYTES_PER_WORD);

  loader_state_e         state_q, state_d;
  logic [CW-1:0]         remain_q, remain_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    word_d    = word_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : word_count;
          idx_d    = '0;
          addr_d   = '0;
          word_d   = '0;
          state_d  = (word_count == '0) ? ST_DONE : ST_RECV;
        end
      end

      ST_RECV: begin
        if (abort) begin
          idx_d   = '0;
          word_d  = '0;
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          word_d[{idx_q, 3'b000} +: BYTE_WIDTH] = byte_data;
          idx_d = idx_q + IW'(1);
          // Output word/address are latched here so they hold steady outside WRITE
          if (idx_q == IW'(BYTES_PER_WORD - 1)) begin
            wr_data_d = word_d;
            wr_addr_d = addr_q;
            state_d   = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (abort) begin
          idx_d   = '0;
          word_d  = '0;
          state_d = ST_IDLE;
        end else begin
          addr_d   = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
          remain_d = remain_q - CW'(1);
          state_d  = (remain_q == CW'(1)) ? ST_DONE : ST_RECV;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; abort suppresses the write strobe
  assign byte_ready = (state_q == ST_RECV);
  assign mem_we     = (state_q == ST_WRITE) && !abort;
  assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign core_hold  = busy;
  assign done       = (state_q == ST_DONE);
  assign mem_addr   = wr_addr_q;
  assign mem_wdata  = wr_data_q;

endmodule : text_memory_loader

// File: tb/tb_text_memory_loader.sv
// Directed bench for text_memory_loader: single word, program load, stalls, zero/clamp,
// abort in RECV and WRITE, ignored start, and reset during a write.
module tb_text_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  word_count = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, core_hold, busy, done;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  text_memory_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int we_cyc = 0;
  int ready_viol = 0;
  int acc_total = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  logic [31:0] prog [8] = '{32'h00052503, 32'h00452583, 32'h00b50633, 32'h00c52423,
                            32'h00150513, 32'hfff58593, 32'hfe059ae3, 32'h00b60a63};

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done observer, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
        we_cyc = cyc;
        if (byte_ready) ready_viol++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] wc);
    start = 1'b1;
    word_count = wc;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int n;
    byte_valid = 1'b1;
    byte_data = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1;
    if (!rdy) check("byte_timeout", 32'd0, 32'd1);
    acc_total++;
    if (acc_total == 1) first_acc_cyc = cyc;
    last_acc_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int n;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        if (n > 0) begin
          byte_valid = 1'b0;
          repeat (n) next_cycle();
        end
      end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic wait_done(input int bound);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt != base), 32'd1);
    next_cycle();
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    acc_total = 0;
  endtask

  initial begin
    int dbase;
    int scyc;

    // Reset state
    #12;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Single word
    clear_log();
    do_start(7'd1);
    check("single_busy", 32'(busy), 32'd1);
    check("single_ready", 32'(byte_ready), 32'd1);
    check("single_hold", 32'(core_hold), 32'd1);
    send_word(32'h00052503, 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    check("single_nwr", 32'(wq_addr.size()), 32'd1);
    check("single_addr", 32'(wq_addr[0]), 32'd0);
    check("single_data", wq_data[0], 32'h00052503);
    check("single_we_lat", 32'(we_cyc - last_acc_cyc), 32'd0);
    check("single_done_lat", 32'(done_cyc - we_cyc), 32'd1);
    check("single_hold_after", 32'(core_hold), 32'd0);
    check("single_wdata_hold", mem_wdata, 32'h00052503);

    // Eight-word program, back-to-back
    clear_log();
    do_start(7'd8);
    for (int i = 0; i < 8; i++) send_word(prog[i], 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    check("prog_nwr", 32'(wq_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("prog_addr%0d", i), 32'(wq_addr[i]), 32'(4 * i));
      check($sformatf("prog_data%0d", i), wq_data[i], prog[i]);
    end
    check("prog_cycles", 32'(done_cyc - first_acc_cyc), 32'd39);

    // Stalled source with random gaps
    clear_log();
    ready_viol = 0;
    do_start(7'd4);
    for (int i = 0; i < 4; i++) send_word(prog[7 - i], 1'b1);
    byte_valid = 1'b0;
    wait_done(40);
    check("stall_nwr", 32'(wq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("stall_data%0d", i), wq_data[i], prog[7 - i]);
    check("stall_ready_in_write", 32'(ready_viol), 32'd0);

    // Zero words
    clear_log();
    do_start(7'd0);
    scyc = cyc;
    wait_done(5);
    check("zero_done_cyc", 32'(done_cyc), 32'(scyc));
    check("zero_nwr", 32'(wq_addr.size()), 32'd0);

    // Clamp 127 -> 64 words
    clear_log();
    do_start(7'd127);
    for (int i = 0; i < 64; i++) send_word(32'hA5000000 | 32'(i), 1'b0);
    byte_valid = 1'b0;
    wait_done(40);
    check("clamp_nwr", 32'(wq_addr.size()), 32'd64);
    if (wq_addr.size() == 64) begin
      check("clamp_first_addr", 32'(wq_addr[0]), 32'd0);
      check("clamp_last_addr", 32'(wq_addr[63]), 32'd252);
      check("clamp_last_data", wq_data[63], 32'hA500003F);
    end
    check("clamp_idle", 32'(busy), 32'd0);

    // Abort after 2 bytes of word 3
    clear_log();
    dbase = done_cnt;
    do_start(7'd5);
    send_word(32'h04030201, 1'b0);
    send_word(32'h08070605, 1'b0);
    send_byte(8'h09);
    send_byte(8'h0a);
    byte_valid = 1'b0;
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(byte_ready), 32'd0);
    repeat (3) next_cycle();
    check("abort_nwr", 32'(wq_addr.size()), 32'd2);
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    do_start(7'd1);
    send_word(32'hdeadbeef, 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    check("reload_nwr", 32'(wq_addr.size()), 32'd3);
    check("reload_addr", 32'(wq_addr[2]), 32'd0);
    check("reload_data", wq_data[2], 32'hdeadbeef);

    // Abort during the WRITE cycle suppresses the write
    clear_log();
    dbase = done_cnt;
    do_start(7'd2);
    send_word(32'h11223344, 1'b0);
    byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort_write_we", 32'(mem_we), 32'd0);
    next_cycle();
    abort = 1'b0;
    check("abort_write_busy", 32'(busy), 32'd0);
    repeat (3) next_cycle();
    check("abort_write_nwr", 32'(wq_addr.size()), 32'd0);
    check("abort_write_no_done", 32'(done_cnt - dbase), 32'd0);

    // Start while busy is ignored
    clear_log();
    dbase = done_cnt;
    do_start(7'd1);
    start = 1'b1;
    word_count = 7'd3;
    next_cycle();
    start = 1'b0;
    send_word(32'hcafef00d, 1'b0);
    byte_valid = 1'b0;
    wait_done(20);
    repeat (8) next_cycle();
    check("busy_start_nwr", 32'(wq_addr.size()), 32'd1);
    check("busy_start_ndone", 32'(done_cnt - dbase), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Reset asserted during WRITE
    clear_log();
    do_start(7'd2);
    send_word(32'h55aa55aa, 1'b0);
    byte_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_mem_we", 32'(mem_we), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_hold", 32'(core_hold), 32'd0);
    check("rstw_ready", 32'(byte_ready), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_addr", 32'(mem_addr), 32'd0);
    check("rstw_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) next_cycle();
    check("rstw_nwr", 32'(wq_addr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_text_memory_loader
